// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) transmitter and its matching decoder.
package hamming_pkg;

   localparam int CODE_W    = 7;
   localparam int DATA_W    = 4;
   localparam int BIT_IDX_W = 3;

   // Codeword index = Hamming position - 1; parity bits sit at the power-of-two positions.
   localparam int P1 = 0;
   localparam int P2 = 1;
   localparam int D0 = 2;
   localparam int P4 = 3;
   localparam int D1 = 4;
   localparam int D2 = 5;
   localparam int D3 = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Single-bit flip mask for error injection: 0 means no error, n flips index n-1.
   function automatic logic [CODE_W-1:0] flip_mask(input logic [2:0] err_pos);
      if (err_pos == 3'd0) begin
         return '0;
      end
      return CODE_W'(1) << (err_pos - 3'd1);
   endfunction

endpackage

// File: rtl/hamming_encoder_74.sv
// Combinational Hamming(7,4) encoder; bit layout matches the single-error-correcting decoder.
module hamming_encoder_74
   import hamming_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [CODE_W-1:0] code_o
);

   // Place data bits at non-power-of-two positions and compute the three even-parity bits.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      code_o     = '0;
      code_o[D0] = data_i[0];
      code_o[D1] = data_i[1];
      code_o[D2] = data_i[2];
      code_o[D3] = data_i[3];
      code_o[P1] = data_i[0] ^ data_i[1] ^ data_i[3];
      code_o[P2] = data_i[0] ^ data_i[2] ^ data_i[3];
      code_o[P4] = data_i[1] ^ data_i[2] ^ data_i[3];
   end

endmodule

// File: rtl/hamming_tx.sv
// Hamming(7,4) transmitter: accepts a nibble, encodes it (with optional single-bit error
// injection) and sends the codeword LSB first as a start / 7 data / stop serial frame.
// The done cycle doubles as the final stop-bit cycle and is already IDLE, so a new nibble
// can be accepted there and frames run back to back.
module hamming_tx
   import hamming_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [2:0]        err_pos,
   output logic [CODE_W-1:0] codeword,
   output logic              tx_serial,
   output logic              busy,
   output logic              done
);

   localparam logic [CNT_W-1:0]     CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
   // STOP holds CLKS_PER_BIT-1 cycles; the done/IDLE cycle supplies the last stop-bit cycle.
   localparam logic [CNT_W-1:0]     CNT_STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [BIT_IDX_W-1:0] BIT_LAST      = BIT_IDX_W'(CODE_W - 1);

   tx_state_t             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIT_IDX_W-1:0]  bit_q, bit_d;
   logic [CODE_W-1:0]     code_q, code_d;
   logic                  tx_q, tx_d;
   logic                  done_q, done_d;
   logic [CODE_W-1:0]     enc_code;
   logic                  accept;
   logic                  bit_end;

   hamming_encoder_74 u_encoder (
      .data_i (data_in),
      .code_o (enc_code)
   );

   assign accept  = data_valid && data_ready;
   assign bit_end = (cnt_q == CNT_LAST);

   // State register and registered serial line; reset aborts any frame and parks the line high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         code_q  <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values together.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         code_q  <= code_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: walk START -> DATA (7 bits) -> STOP, advancing on bit-period wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      code_d  = code_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               code_d  = enc_code ^ flip_mask(err_pos);
               state_d = START;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == BIT_LAST) begin
                  // With one clock per bit the done cycle is the whole stop bit.
                  if (CLKS_PER_BIT == 1) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = STOP;
                  end
               end else begin
                  bit_d = bit_q + BIT_IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == CNT_STOP_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: handshake/status from current state, serial level from the next state.
   always_comb begin
      data_ready = (state_q == IDLE);
      busy       = (state_q != IDLE) || done_q;
      tx_d       = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = code_d[bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   assign tx_serial = tx_q;
   assign done      = done_q;
   assign codeword  = code_q;

endmodule

// File: tb/tb_hamming_tx.sv
// Self-checking bench for hamming_tx: one DUT at 4 clocks/bit and one at 1 clock/bit,
// checked cycle by cycle against a position-based Hamming model and a reference decoder.
module tb_hamming_tx;

   logic       clk;
   logic       rst;
   logic [3:0] data_in;
   logic [2:0] err_pos;
   logic       data_valid;
   bit         sel;          // 0 = 4 clocks/bit DUT, 1 = 1 clock/bit DUT

   logic       valid4, rdy4, tx4, busy4, done4;
   logic       valid1, rdy1, tx1, busy1, done1;
   logic [6:0] cw4, cw1;
   logic       tx_s, rdy_s, busy_s, done_s;
   logic [6:0] cw_s;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   assign valid4 = data_valid & ~sel;
   assign valid1 = data_valid & sel;
   assign tx_s   = sel ? tx1   : tx4;
   assign rdy_s  = sel ? rdy1  : rdy4;
   assign busy_s = sel ? busy1 : busy4;
   assign done_s = sel ? done1 : done4;
   assign cw_s   = sel ? cw1   : cw4;

   hamming_tx #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(valid4), .data_ready(rdy4),
      .err_pos(err_pos), .codeword(cw4), .tx_serial(tx4), .busy(busy4), .done(done4)
   );

   hamming_tx #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(valid1), .data_ready(rdy1),
      .err_pos(err_pos), .codeword(cw1), .tx_serial(tx1), .busy(busy1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Reference encoder: data bits fill non-power-of-two positions in order; parity at
   // position 2^k covers every other position whose number has bit k set.
   function automatic logic [6:0] model_enc(input logic [3:0] d);
      logic [6:0] c;
      logic       par;
      int         j;
      c = '0;
      j = 0;
      for (int p = 1; p <= 7; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p-1] = d[j];
            j++;
         end
      end
      for (int k = 0; k < 3; k++) begin
         par = 1'b0;
         for (int p = 1; p <= 7; p++) begin
            if (p[k] && p != (1 << k)) par ^= c[p-1];
         end
         c[(1 << k) - 1] = par;
      end
      return c;
   endfunction

   function automatic logic [6:0] model_mask(input logic [2:0] e);
      logic [6:0] m;
      m = '0;
      if (e != 3'd0) m[int'(e) - 1] = 1'b1;
      return m;
   endfunction

   // Reference decoder: syndrome is the XOR of the positions of all set bits.
   task automatic model_dec(input logic [6:0] c, output logic [2:0] syn, output logic [3:0] d);
      logic [6:0] fix;
      syn = '0;
      for (int p = 1; p <= 7; p++) begin
         if (c[p-1]) syn ^= 3'(p);
      end
      fix = c;
      if (syn != 3'd0) fix[int'(syn) - 1] = ~fix[int'(syn) - 1];
      d = {fix[6], fix[5], fix[4], fix[2]};
   endtask

   task automatic start_frame(input logic [3:0] nib, input logic [2:0] err, input string tag);
      @(negedge clk);
      chk_cnt++;
      if (rdy_s !== 1'b1) $display("FAIL %s ready_before_accept: got %b want 1", tag, rdy_s);
      else pass_cnt++;
      data_in    = nib;
      err_pos    = err;
      data_valid = 1'b1;
   endtask

   // Checks every cycle of a frame; optionally keeps data_valid high with junk data while
   // busy and optionally presents the next nibble in the done cycle.
   task automatic check_frame(input logic [6:0] exp_code, input int cpb, input bit hold,
                              input bit chain, input logic [3:0] nib2, input logic [2:0] err2,
                              input string tag);
      int         n;
      int         idx;
      logic       exp_tx;
      logic [10:0] obs, exp;
      n = 9 * cpb;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         idx = (k - 1) / cpb;
         if (idx == 0)      exp_tx = 1'b0;
         else if (idx == 8) exp_tx = 1'b1;
         else               exp_tx = exp_code[idx-1];
         obs = {cw_s, tx_s, done_s, busy_s, rdy_s};
         exp = {exp_code, exp_tx, (k == n), 1'b1, (k == n)};
         chk_cnt++;
         if (obs !== exp)
            $display("FAIL %s cycle %0d {cw,tx,done,busy,rdy}: got %h_%b%b%b%b want %h_%b%b%b%b",
                     tag, k, obs[10:4], obs[3], obs[2], obs[1], obs[0],
                     exp[10:4], exp[3], exp[2], exp[1], exp[0]);
         else pass_cnt++;
         if (k < n) begin
            data_valid = hold;
            data_in    = 4'($urandom);
            err_pos    = 3'($urandom);
         end else if (chain) begin
            data_valid = 1'b1;
            data_in    = nib2;
            err_pos    = err2;
         end else begin
            data_valid = 1'b0;
         end
      end
   endtask

   task automatic check_decode(input logic [2:0] exp_syn, input logic [3:0] exp_data,
                               input string tag);
      logic [2:0] syn;
      logic [3:0] d;
      model_dec(cw_s, syn, d);
      chk_cnt++;
      if ({syn, d} !== {exp_syn, exp_data})
         $display("FAIL %s decode: got syn %b data %b want syn %b data %b",
                  tag, syn, d, exp_syn, exp_data);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      sel        = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      err_pos    = '0;
      #2;
      chk_cnt++;
      if ({tx4, rdy4, busy4, done4, cw4} !== {4'b1100, 7'h00})
         $display("FAIL reset_cpb4: got %b%b%b%b cw %h want 1100 cw 00", tx4, rdy4, busy4, done4, cw4);
      else pass_cnt++;
      chk_cnt++;
      if ({tx1, rdy1, busy1, done1, cw1} !== {4'b1100, 7'h00})
         $display("FAIL reset_cpb1: got %b%b%b%b cw %h want 1100 cw 00", tx1, rdy1, busy1, done1, cw1);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      sel = 1'b0;
      start_frame(4'b1011, 3'd0, "d1011");
      check_frame(7'h55, 4, 1'b0, 1'b0, 4'h0, 3'd0, "d1011");
      check_decode(3'd0, 4'b1011, "d1011");
      start_frame(4'b0001, 3'd0, "d0001");
      check_frame(7'h07, 4, 1'b0, 1'b0, 4'h0, 3'd0, "d0001");
      check_decode(3'd0, 4'b0001, "d0001");
      start_frame(4'b1111, 3'd0, "d1111");
      check_frame(7'h7F, 4, 1'b0, 1'b0, 4'h0, 3'd0, "d1111");
      check_decode(3'd0, 4'b1111, "d1111");
      start_frame(4'b0000, 3'd0, "d0000");
      check_frame(7'h00, 4, 1'b0, 1'b0, 4'h0, 3'd0, "d0000");
      check_decode(3'd0, 4'b0000, "d0000");
      start_frame(4'b1011, 3'd5, "d1011_e5");
      check_frame(7'h45, 4, 1'b0, 1'b0, 4'h0, 3'd0, "d1011_e5");
      check_decode(3'b101, 4'b1011, "d1011_e5");
      sel = 1'b1;
      start_frame(4'b0110, 3'd0, "c1_0110");
      check_frame(7'h33, 1, 1'b0, 1'b0, 4'h0, 3'd0, "c1_0110");
      check_decode(3'd0, 4'b0110, "c1_0110");
   endtask

   task automatic test_sweep();
      sel = 1'b1;
      for (int n = 0; n < 16; n++) begin
         for (int e = 0; e < 8; e++) begin
            start_frame(4'(n), 3'(e), "sweep");
            check_frame(model_enc(4'(n)) ^ model_mask(3'(e)), 1, 1'b0, 1'b0, 4'h0, 3'd0, "sweep");
            check_decode(3'(e), 4'(n), "sweep");
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] nib;
      logic [2:0] err;
      for (int i = 0; i < 24; i++) begin
         sel = 1'($urandom);
         nib = 4'($urandom);
         err = 3'($urandom);
         start_frame(nib, err, "rand");
         check_frame(model_enc(nib) ^ model_mask(err), sel ? 1 : 4, 1'($urandom), 1'b0,
                     4'h0, 3'd0, "rand");
         check_decode(err, nib, "rand");
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] a, b;
      logic [2:0] eb;
      sel = 1'b0;
      a   = 4'($urandom);
      b   = 4'($urandom);
      eb  = 3'($urandom);
      start_frame(a, 3'd0, "b2b_first");
      check_frame(model_enc(a), 4, 1'b1, 1'b1, b, eb, "b2b_first");
      check_frame(model_enc(b) ^ model_mask(eb), 4, 1'b0, 1'b0, 4'h0, 3'd0, "b2b_second");
      check_decode(eb, b, "b2b_second");
   endtask

   task automatic test_mid_reset();
      int done_seen;
      int low_seen;
      sel = 1'b0;
      start_frame(4'b1011, 3'd0, "midrst");
      @(negedge clk);
      data_valid = 1'b0;
      repeat (14) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk_cnt++;
      if ({tx_s, busy_s, rdy_s, done_s, cw_s} !== {4'b1010, 7'h00})
         $display("FAIL midrst_async {tx,busy,rdy,done} cw: got %b%b%b%b %h want 1010 00",
                  tx_s, busy_s, rdy_s, done_s, cw_s);
      else pass_cnt++;
      @(negedge clk);
      rst       = 1'b0;
      done_seen = 0;
      low_seen  = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done_s) done_seen++;
         if (!tx_s || busy_s) low_seen++;
      end
      chk_cnt++;
      if ({done_seen, low_seen} !== {32'd0, 32'd0})
         $display("FAIL midrst_after: got done %0d busy/low %0d want 0 0", done_seen, low_seen);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_sweep();
      test_random();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
